uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between several byte-stream requesters: the RX echo path, the core's output port and a debug/status source. Each requester offers packets of bytes on a valid/ready/last interface. The arbiter locks the TX to one requester for a whole packet and forwards bytes one at a time over the TX data/valid/ready handshake. It sits in the top level between the requesters and the TX instance. A watchdog releases the grant if a requester stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between NUM_REQ packet sources; grant is held for a whole packet.
// Grant registers one cycle after valid. Bytes pass through combinationally with tx_ready as backpressure; a watchdog frees stalled owners.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]         state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [PTR_W-1:0]   owner_q,   owner_d;
    logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]   wd_cnt_q,  wd_cnt_d;
    logic               timeout_q, timeout_d;

    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               own_vld;
    logic               own_last;
    logic               xfer;
    logic               rel_grant;
    logic [PTR_W-1:0]   owner_next;
    logic [DATA_WIDTH-1:0] own_data;

    // Two passes give the rotating priority: first rr_ptr..NUM_REQ-1, then wrap to 0..rr_ptr-1.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_valid_i[i] && (i >= int'(rr_ptr_q))) begin
                pick_vld   = 1'b1;
                pick_idx   = PTR_W'(i);
                pick_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_valid_i[i] && (i < int'(rr_ptr_q))) begin
                pick_vld   = 1'b1;
                pick_idx   = PTR_W'(i);
                pick_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_data = own_data | req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign own_vld    = |(grant_q & req_valid_i);
    assign own_last   = |(grant_q & req_last_i);
    assign xfer       = own_vld & tx_ready_i;
    assign owner_next = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        rel_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d  = ST_GRANT;
                    grant_d  = pick_oh;
                    owner_d  = pick_idx;
                    wd_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                // Only a silent owner ages the watchdog; TX backpressure with valid held is legitimate.
                if (xfer) begin
                    wd_cnt_d  = '0;
                    rel_grant = own_last;
                end else if (!own_vld && (TIMEOUT_CYC > 0)) begin
                    if (wd_cnt_q == CNT_LAST) begin
                        rel_grant = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        if (rel_grant) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            wd_cnt_d = '0;
            rr_ptr_d = owner_next;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = (state_q == ST_GRANT);
    assign timeout_o   = timeout_q;
    assign tx_valid_o  = own_vld;
    assign tx_data_o   = own_data;
    assign req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, an integer-level arbitration model and directed literal checks.
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] req_data  = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last  = '0;
    logic           tx_ready  = 1'b0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .reset_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_last_i(req_last), .req_ready_o(req_ready), .tx_data_o(tx_data),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .grant_o(grant),
        .busy_o(busy), .timeout_o(timeout)
    );

    logic [N*W-1:0] b_req_data  = '0;
    logic [N-1:0]   b_req_valid = '0;
    logic [N-1:0]   b_req_last  = '0;
    logic           b_tx_ready  = 1'b0;
    logic [N-1:0]   b_req_ready;
    logic [W-1:0]   b_tx_data;
    logic           b_tx_valid;
    logic [N-1:0]   b_grant;
    logic           b_busy;
    logic           b_timeout;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYC(0)) dut_nowd (
        .clk_i(clk), .reset_i(rst), .req_data_i(b_req_data), .req_valid_i(b_req_valid),
        .req_last_i(b_req_last), .req_ready_o(b_req_ready), .tx_data_o(b_tx_data),
        .tx_valid_o(b_tx_valid), .tx_ready_i(b_tx_ready), .grant_o(b_grant),
        .busy_o(b_busy), .timeout_o(b_timeout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Requester byte queues: bit 8 is the last flag.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    task automatic push(input int r, input logic last, input logic [7:0] d);
        case (r)
            0:       q0.push_back({last, d});
            1:       q1.push_back({last, d});
            default: q2.push_back({last, d});
        endcase
    endtask

    function automatic int qsize(input int r);
        case (r)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] qhead(input int r);
        case (r)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    logic [N-1:0] acc = '0;
    logic [8:0]   drv_h;

    initial forever begin
        @(negedge clk);
        acc = req_valid & req_ready;
    end

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            if (acc[0] && q0.size() > 0) void'(q0.pop_front());
            if (acc[1] && q1.size() > 0) void'(q1.pop_front());
            if (acc[2] && q2.size() > 0) void'(q2.pop_front());
        end
        #1;
        for (int r = 0; r < N; r++) begin
            if (qsize(r) > 0) begin
                drv_h            = qhead(r);
                req_valid[r]     = 1'b1;
                req_last[r]      = drv_h[8];
                req_data[r*W +: W] = drv_h[7:0];
            end else begin
                req_valid[r] = 1'b0;
                req_last[r]  = 1'b0;
            end
        end
    end

    // Model: owner index (-1 when idle), next-priority index, silent-cycle count.
    int m_own = -1;
    int m_rr  = 0;
    int m_wd  = 0;
    bit m_to  = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_own = -1; m_rr = 0; m_wd = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_own < 0 && req_valid[(m_rr + k) % N]) begin
                        m_own = (m_rr + k) % N;
                        m_wd  = 0;
                    end
                end
            end else if (req_valid[m_own] && tx_ready) begin
                m_wd = 0;
                if (req_last[m_own]) begin
                    m_rr  = (m_own + 1) % N;
                    m_own = -1;
                end
            end else if (!req_valid[m_own]) begin
                m_wd++;
                if (m_wd == TO) begin
                    m_to  = 1'b1;
                    m_rr  = (m_own + 1) % N;
                    m_own = -1;
                    m_wd  = 0;
                end
            end
        end
    end

    logic [N-1:0] e_grant, e_ready;
    logic [W-1:0] e_data;
    logic         e_valid;

    initial forever begin
        @(negedge clk);
        e_grant = '0; e_ready = '0; e_data = '0; e_valid = 1'b0;
        if (m_own >= 0) begin
            e_grant[m_own] = 1'b1;
            e_ready[m_own] = tx_ready;
            e_valid        = req_valid[m_own];
            e_data         = req_data[m_own*W +: W];
        end
        check("m_grant",   32'(grant),    32'(e_grant));
        check("m_busy",    32'(busy),     32'(m_own >= 0));
        check("m_txvalid", 32'(tx_valid), 32'(e_valid));
        check("m_txdata",  32'(tx_data),  32'(e_data));
        check("m_ready",   32'(req_ready), 32'(e_ready));
        check("m_timeout", 32'(timeout),  32'(m_to));
        check("a_valid_needs_grant", 32'(tx_valid && (grant == '0)), 32'd0);
        check("a_ready_onehot0",     32'($countones(req_ready) <= 1), 32'd1);
    end

    // Grant-order monitor: records each new grant and the idle cycles preceding it.
    logic [N-1:0] prev_g = '0;
    int           idle_run = 0;
    logic [N-1:0] g_order[$];
    int           gaps[$];

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_g = '0; idle_run = 0;
        end else begin
            if (grant == '0) idle_run++;
            else if (prev_g == '0) begin
                g_order.push_back(grant);
                gaps.push_back(idle_run);
                idle_run = 0;
            end
            prev_g = grant;
        end
    end

    task automatic check_order(input string nm, input int n, input logic [23:0] e);
        check({nm, "_count"}, 32'(g_order.size()), 32'(n));
        for (int k = 0; k < n && k < g_order.size(); k++) begin
            check({nm, "_grant"}, 32'(g_order[k]), 32'(e[k*4 +: 3]));
            if (k > 0) check({nm, "_gap"}, 32'(gaps[k]), 32'd1);
        end
    endtask

    task automatic wait_idle(input string nm, input int max);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < max) begin
            @(negedge clk);
            k++;
            done = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) &&
                   (req_valid == '0) && (grant == '0);
        end
        check({nm, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic clear_order();
        g_order.delete();
        gaps.delete();
    endtask

    bit found;
    bit held;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_grant",   32'(grant),     32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_txvalid", 32'(tx_valid),  32'd0);
        check("rst_txdata",  32'(tx_data),   32'd0);
        check("rst_ready",   32'(req_ready), 32'd0);
        check("rst_timeout", 32'(timeout),   32'd0);
        @(posedge clk); #1 rst = 1'b0; tx_ready = 1'b1;

        // Single packet from requester 1.
        @(negedge clk);
        push(1, 1'b0, 8'h41); push(1, 1'b0, 8'h42); push(1, 1'b1, 8'h43);
        @(negedge clk);
        check("sp_pre_grant", 32'(grant), 32'd0);
        @(negedge clk);
        check("sp_grant", 32'(grant), 32'b010);
        check("sp_busy",  32'(busy),  32'd1);
        check("sp_b0",    32'(tx_data), 32'h41);
        @(negedge clk);
        check("sp_b1",    32'(tx_data), 32'h42);
        @(negedge clk);
        check("sp_b2",    32'(tx_data), 32'h43);
        check("sp_ready", 32'(req_ready), 32'b010);
        @(negedge clk);
        check("sp_release", 32'(grant), 32'd0);
        check("sp_idle",    32'(busy),  32'd0);

        // Pointer now at 2: requester 2 beats requester 0.
        clear_order();
        push(0, 1'b1, 8'h01); push(2, 1'b1, 8'h02);
        wait_idle("ptr2", 40);
        check_order("ptr2", 2, 24'h000014);

        // Round-robin: three requesters, two 2-byte packets each, from reset.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clear_order();
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < 2; p++) begin
                push(r, 1'b0, 8'(8'h10 * (r + 1) + p * 2));
                push(r, 1'b1, 8'(8'h10 * (r + 1) + p * 2 + 1));
            end
        end
        wait_idle("rr", 200);
        check_order("rr", 6, 24'h421421);

        // Backpressure: TX stalls 20 cycles on requester 0's second byte.
        push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h55); push(0, 1'b1, 8'h66);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = (grant == 3'b001) && (tx_data == 8'h11);
        end
        check("bp_start", 32'(found), 32'd1);
        @(posedge clk); #1 tx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_hold_data",    32'(tx_data),  32'h55);
            check("bp_hold_valid",   32'(tx_valid), 32'd1);
            check("bp_hold_timeout", 32'(timeout),  32'd0);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        check("bp_next_byte", 32'(tx_data), 32'h66);
        wait_idle("bp", 20);

        // Watchdog: requester 2 goes silent mid-packet, requester 0 waits.
        push(2, 1'b0, 8'hA7);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = (grant == 3'b100) && tx_valid;
        end
        check("wd_start", 32'(found), 32'd1);
        push(0, 1'b1, 8'h30);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("wd_no_pulse_yet", 32'(timeout), 32'd0);
            check("wd_still_owner",  32'(grant),   32'b100);
        end
        @(negedge clk);
        check("wd_pulse",      32'(timeout), 32'd1);
        check("wd_grant_drop", 32'(grant),   32'd0);
        @(negedge clk);
        check("wd_pulse_end",  32'(timeout), 32'd0);
        check("wd_next_owner", 32'(grant),   32'b001);
        wait_idle("wd", 20);

        // Reset mid-packet during byte 2 of requester 1.
        push(1, 1'b0, 8'hC1); push(1, 1'b0, 8'hC2); push(1, 1'b0, 8'hC3); push(1, 1'b1, 8'hC4);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = (grant == 3'b010) && (tx_data == 8'hC2);
        end
        check("mr_start", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_grant",   32'(grant),     32'd0);
        check("mr_busy",    32'(busy),      32'd0);
        check("mr_txvalid", 32'(tx_valid),  32'd0);
        check("mr_ready",   32'(req_ready), 32'd0);
        q0.delete(); q1.delete(); q2.delete();
        @(negedge clk);
        rst = 1'b0;
        clear_order();
        push(2, 1'b1, 8'hE2); push(0, 1'b1, 8'hE0);
        wait_idle("mr", 40);
        check_order("mr_restart", 2, 24'h000041);

        // No-watchdog instance holds the grant indefinitely.
        @(posedge clk); #1;
        b_req_data  = {16'h0000, 8'h99};
        b_req_last  = '0;
        b_req_valid = 3'b001;
        b_tx_ready  = 1'b1;
        @(negedge clk);
        check("nowd_pre", 32'(b_grant), 32'd0);
        @(negedge clk);
        check("nowd_grant", 32'(b_grant),   32'b001);
        check("nowd_data",  32'(b_tx_data), 32'h99);
        @(posedge clk); #1 b_req_valid = '0;
        held = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b_grant !== 3'b001 || b_timeout !== 1'b0 || b_busy !== 1'b1) held = 1'b0;
        end
        check("nowd_hold",    32'(held),       32'd1);
        check("nowd_txvalid", 32'(b_tx_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
